// File: rtl/wb_burst_sram_responder_if.sv
// wb_burst_sram_responder_if: Wishbone request/response bus with burst flags
interface wb_burst_sram_responder_if #(parameter int DW = 16, parameter int AW = 24);
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_i_dat;
  logic [DW/8-1:0] wb_sel;
  logic          wb_4_burst;
  logic          wb_8_burst;
  logic          wb_ack;
  logic          wb_err;
  logic [DW-1:0] wb_o_dat;
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel, wb_4_burst, wb_8_burst,
    input  wb_ack, wb_err, wb_o_dat
  );
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel, wb_4_burst, wb_8_burst,
    output wb_ack, wb_err, wb_o_dat
  );
endinterface

// File: rtl/wb_burst_sram_responder.sv
// wb_burst_sram_responder: Wishbone single/4/8-beat wrapping burst responder in front of a sync SRAM
module wb_burst_sram_responder #(
  parameter int DW     = 16,
  parameter int AW     = 24,
  parameter int MEM_AW = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  wb_burst_sram_responder_if.slave wb,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DW/8-1:0]     mem_wmask,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
  state_t state;
  logic [2:0] cnt, msk, nk;
  logic [MEM_AW-1:0] base;
  logic [DW-1:0] dat_q;
  logic req, bad, rd_beat;
  always_comb begin
    req     = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack & ~wb.wb_err;
    bad     = (|wb.wb_adr[AW-1:MEM_AW]) | (wb.wb_4_burst & wb.wb_8_burst) |
              (wb.wb_we & (wb.wb_4_burst | wb.wb_8_burst));
    nk      = cnt + 3'd1;
    rd_beat = wb.wb_ack & (state == RD);
  end
  assign wb.wb_o_dat = rd_beat ? mem_rdata : dat_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      wb.wb_ack <= 1'b0;
      wb.wb_err <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      dat_q     <= '0;
      base      <= '0;
      cnt       <= '0;
      msk       <= '0;
    end else begin
      if (rd_beat) dat_q <= mem_rdata;
      case (state)
        IDLE: if (req) begin
          if (bad) begin
            state     <= ERR;
            wb.wb_err <= 1'b1;
          end else if (wb.wb_we) begin
            state     <= WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wb.wb_adr[MEM_AW-1:0];
            mem_wmask <= wb.wb_sel;
            mem_wdata <= wb.wb_i_dat;
            wb.wb_ack <= 1'b1;
          end else begin
            state    <= RD;
            mem_en   <= 1'b1;
            mem_addr <= wb.wb_adr[MEM_AW-1:0];
            base     <= wb.wb_adr[MEM_AW-1:0];
            cnt      <= 3'd0;
            msk      <= wb.wb_8_burst ? 3'd7 : wb.wb_4_burst ? 3'd3 : 3'd0;
          end
        end
        RD: begin
          // each issued read is acked one cycle later; abort drops whatever is in flight
          if (!wb.wb_cyc || !mem_en) begin
            wb.wb_ack <= 1'b0;
            mem_en    <= 1'b0;
            state     <= IDLE;
          end else begin
            wb.wb_ack <= 1'b1;
            if (cnt == msk) mem_en <= 1'b0;
            else begin
              cnt      <= nk;
              mem_addr <= {base[MEM_AW-1:3], (base[2:0] & ~msk) | ((base[2:0] + nk) & msk)};
            end
          end
        end
        WR: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          wb.wb_ack <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          wb.wb_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_sram_responder.sv
// tb_wb_burst_sram_responder: directed checks of reads, wrapping bursts, writes, errors, abort and async reset
module tb_wb_burst_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [1:0] mem_wmask;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] sram [1024];
  logic [15:0] e [8];
  int n_cmp = 0;
  int n_bad = 0;
  wb_burst_sram_responder_if #(.DW(16), .AW(24)) bus ();
  wb_burst_sram_responder #(.DW(16), .AW(24), .MEM_AW(10)) dut (
    .i_clk(clk), .i_rst(rst), .wb(bus.slave),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_wmask[0]) sram[mem_addr][7:0] <= mem_wdata[7:0];
        if (mem_wmask[1]) sram[mem_addr][15:8] <= mem_wdata[15:8];
      end else mem_rdata <= sram[mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_bus;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we = 1'b0;
    bus.wb_4_burst = 1'b0;
    bus.wb_8_burst = 1'b0;
  endtask
  task automatic request(input logic [23:0] a, input logic we, input logic b4, input logic b8,
                         input logic [15:0] d, input logic [1:0] s);
    bus.wb_cyc = 1'b1;
    bus.wb_stb = 1'b1;
    bus.wb_we = we;
    bus.wb_adr = a;
    bus.wb_i_dat = d;
    bus.wb_sel = s;
    bus.wb_4_burst = b4;
    bus.wb_8_burst = b8;
  endtask
  task automatic wr(input logic [23:0] a, input logic [15:0] d, input logic [1:0] s);
    request(a, 1'b1, 1'b0, 1'b0, d, s);
    step;
    chk("wr_ack", bus.wb_ack, 1);
    chk("wr_en_we", {mem_en, mem_we}, 2'b11);
    chk("wr_addr", mem_addr, a[9:0]);
    chk("wr_mask", mem_wmask, s);
    chk("wr_data", mem_wdata, d);
    idle_bus;
    step;
    chk("wr_ack_end", bus.wb_ack, 0);
    chk("wr_en_end", mem_en, 0);
  endtask
  task automatic rd(input string tag, input logic [23:0] a, input logic b4, input logic b8,
                    input int n, input logic [15:0] x [8]);
    request(a, 1'b0, b4, b8, 16'h0, 2'b00);
    step;
    chk({tag, "_en0"}, {mem_en, mem_we}, 2'b10);
    chk({tag, "_addr0"}, mem_addr, a[9:0]);
    chk({tag, "_lat"}, bus.wb_ack, 0);
    for (int k = 0; k < n; k++) begin
      step;
      chk($sformatf("%s_ack%0d", tag, k), bus.wb_ack, 1);
      chk($sformatf("%s_dat%0d", tag, k), bus.wb_o_dat, x[k]);
      chk($sformatf("%s_en%0d", tag, k + 1), mem_en, (k < n - 1) ? 1 : 0);
    end
    idle_bus;
    step;
    chk({tag, "_ack_end"}, bus.wb_ack, 0);
    chk({tag, "_en_end"}, mem_en, 0);
    chk({tag, "_hold"}, bus.wb_o_dat, x[n-1]);
  endtask
  task automatic err_req(input string tag, input logic [23:0] a, input logic we,
                         input logic b4, input logic b8);
    request(a, we, b4, b8, 16'hFFFF, 2'b11);
    step;
    chk({tag, "_err"}, bus.wb_err, 1);
    chk({tag, "_ack"}, bus.wb_ack, 0);
    chk({tag, "_en"}, mem_en, 0);
    idle_bus;
    step;
    chk({tag, "_err_end"}, bus.wb_err, 0);
    chk({tag, "_en_end"}, mem_en, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    idle_bus;
    bus.wb_adr = '0;
    bus.wb_i_dat = '0;
    bus.wb_sel = '0;
    repeat (2) step;
    chk("rst_ack", bus.wb_ack, 0);
    chk("rst_err", bus.wb_err, 0);
    chk("rst_en_we", {mem_en, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mask", mem_wmask, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_odat", bus.wb_o_dat, 0);
    rst = 1'b0;
    step;
    wr(24'h12, 16'hBEEF, 2'b11);
    for (int i = 0; i < 4; i++) wr(24'h20 + 24'(i), 16'h00A0 + 16'(i), 2'b11);
    for (int i = 0; i < 8; i++) wr(24'h40 + 24'(i), 16'h1100 + 16'(i), 2'b11);
    wr(24'h50, 16'h5555, 2'b11);
    for (int i = 0; i < 8; i++) wr(24'h60 + 24'(i), 16'h6000 + 16'(i), 2'b11);
    e[0] = 16'hBEEF;
    rd("single", 24'h12, 1'b0, 1'b0, 1, e);
    e[0] = 16'h00A2; e[1] = 16'h00A3; e[2] = 16'h00A0; e[3] = 16'h00A1;
    rd("wrap4", 24'h22, 1'b1, 1'b0, 4, e);
    for (int i = 0; i < 8; i++) e[i] = 16'h1100 + 16'(i);
    rd("burst8", 24'h40, 1'b0, 1'b1, 8, e);
    wr(24'h41, 16'h1234, 2'b01);
    e[0] = 16'h1134;
    rd("bytewr", 24'h41, 1'b0, 1'b0, 1, e);
    err_req("range", 24'h000400, 1'b0, 1'b0, 1'b0);
    err_req("range_hi", 24'h800000, 1'b0, 1'b0, 1'b0);
    err_req("both", 24'h20, 1'b0, 1'b1, 1'b1);
    err_req("wrburst", 24'h50, 1'b1, 1'b1, 1'b0);
    e[0] = 16'h5555;
    rd("unchanged", 24'h50, 1'b0, 1'b0, 1, e);
    request(24'h60, 1'b0, 1'b0, 1'b1, 16'h0, 2'b00);
    step;
    chk("abort_en0", mem_en, 1);
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("abort_ack%0d", k), bus.wb_ack, 1);
      chk($sformatf("abort_dat%0d", k), bus.wb_o_dat, 16'h6000 + 16'(k));
    end
    idle_bus;
    for (int k = 0; k < 2; k++) begin
      step;
      chk($sformatf("abort_noack%0d", k), bus.wb_ack, 0);
      chk($sformatf("abort_noen%0d", k), mem_en, 0);
    end
    e[0] = 16'hBEEF;
    rd("post_abort", 24'h12, 1'b0, 1'b0, 1, e);
    request(24'h40, 1'b0, 1'b0, 1'b1, 16'h0, 2'b00);
    repeat (3) step;
    chk("arst_pre_ack", bus.wb_ack, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", bus.wb_ack, 0);
    chk("arst_en", mem_en, 0);
    idle_bus;
    #2 rst = 1'b0;
    step;
    chk("arst_after_ack", bus.wb_ack, 0);
    chk("arst_after_en", mem_en, 0);
    rd("post_arst", 24'h12, 1'b0, 1'b0, 1, e);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
